// File: rtl/multi_lift_hall_dispatcher_pkg.sv
// Shared types for the hall-call dispatcher: call slot / dispatcher FSM states
// and the floor/direction -> slot mapping.
package lift_ctrl_pkg;

  typedef enum logic [1:0] {CALL_IDLE, CALL_PENDING, CALL_ASSIGNED} call_state_e;
  typedef enum logic       {DISP_SCAN, DISP_OFFER}                  disp_state_e;

  // slot 2*f is the down call at floor f, 2*f+1 the up call
  function automatic int unsigned slot_index(input int unsigned floor, input logic dir);
    return 2 * floor + {31'd0, dir};
  endfunction

endpackage

// File: rtl/multi_lift_hall_dispatcher_if.sv
// Assignment offer handshake between the hall dispatcher and the lift controllers.
interface multi_lift_hall_dispatcher_if #(
  parameter int N_FLOORS = 12,
  parameter int N_LIFTS  = 10
);
  localparam int FLOOR_W = $clog2(N_FLOORS);
  localparam int LIFT_W  = (N_LIFTS > 1) ? $clog2(N_LIFTS) : 1;

  logic               assign_valid;
  logic [LIFT_W-1:0]  assign_lift;
  logic [FLOOR_W-1:0] assign_floor;
  logic               assign_up;
  logic               assign_ack;

  modport master (output assign_valid, assign_lift, assign_floor, assign_up, input assign_ack);
  modport slave  (input assign_valid, assign_lift, assign_floor, assign_up, output assign_ack);
endinterface

// File: rtl/multi_lift_hall_dispatcher_lift_selector.sv
// Combinational nearest-eligible-lift picker for one hall call; ties go to the
// lowest lift index.
module lift_selector #(
  parameter int N_LIFTS = 10,
  parameter int FLOOR_W = 4,
  parameter int LIFT_W  = 4
) (
  input  logic [N_LIFTS*FLOOR_W-1:0] lift_floor,
  input  logic [N_LIFTS-1:0]         lift_idle,
  input  logic [N_LIFTS-1:0]         lift_moving_up,
  input  logic [FLOOR_W-1:0]         call_floor,
  input  logic                       call_up,
  output logic                       found,
  output logic [LIFT_W-1:0]          best_lift
);
  logic [N_LIFTS-1:0]              elig;
  logic [N_LIFTS-1:0][FLOOR_W-1:0] cost;
  logic [FLOOR_W-1:0]              best_cost;

  for (genvar i = 0; i < N_LIFTS; i++) begin : g_lift
    logic [FLOOR_W-1:0] lf;
    assign lf      = lift_floor[i*FLOOR_W +: FLOOR_W];
    // a moving lift only takes calls ahead of it in its own direction
    assign elig[i] = lift_idle[i]
                   | ( lift_moving_up[i] &  call_up & (lf < call_floor))
                   | (~lift_moving_up[i] & ~call_up & (lf > call_floor));
    assign cost[i] = (lf > call_floor) ? lf - call_floor : call_floor - lf;
  end

  always_comb begin
    found     = 1'b0;
    best_lift = '0;
    best_cost = '0;
    for (int i = 0; i < N_LIFTS; i++) begin
      if (elig[i] && (!found || cost[i] < best_cost)) begin
        found     = 1'b1;
        best_lift = LIFT_W'(i);
        best_cost = cost[i];
      end
    end
  end
endmodule

// File: rtl/multi_lift_hall_dispatcher.sv
// Hall-call dispatcher: latches button presses into call slots, offers each pending
// call to the nearest eligible lift, clears on service. HALL_CALL_REASSIGN_EN adds
// per-slot age counters that return unserved ASSIGNED calls to PENDING after TIMEOUT.
module multi_lift_hall_dispatcher import lift_ctrl_pkg::*; #(
  parameter int N_FLOORS = 12,
  parameter int N_LIFTS  = 10
`ifdef HALL_CALL_REASSIGN_EN
  , parameter int TIMEOUT = 255
`endif
  , localparam int FLOOR_W = $clog2(N_FLOORS)
  , localparam int LIFT_W  = (N_LIFTS > 1) ? $clog2(N_LIFTS) : 1
  , localparam int CNT_W   = $clog2(2*N_FLOORS+1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_FLOORS-1:0]        up_rqst,
  input  logic [N_FLOORS-1:0]        dn_rqst,
  input  logic [N_LIFTS*FLOOR_W-1:0] lift_floor,
  input  logic [N_LIFTS-1:0]         lift_idle,
  input  logic [N_LIFTS-1:0]         lift_moving_up,
  input  logic                       serve_valid,
  input  logic [FLOOR_W-1:0]         serve_floor,
  input  logic                       serve_up,
  multi_lift_hall_dispatcher_if.master asg,
  output logic [N_FLOORS-1:0]        global_up_rqst_status,
  output logic [N_FLOORS-1:0]        global_dn_rqst_status,
  output logic [CNT_W-1:0]           pending_count
);
  localparam int NS    = 2 * N_FLOORS;
  localparam int PTR_W = $clog2(NS);

  call_state_e       slot_q [NS];
  call_state_e       slot_d [NS];
  disp_state_e       state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_nxt;
  logic [NS-1:0]     press, serve_hit, slot_ok;
  logic              load, accept, offer_gone, sel_found;
  logic [LIFT_W-1:0] sel_lift;
  logic [CNT_W-1:0]  pend_n;

`ifdef HALL_CALL_REASSIGN_EN
  localparam int AGE_W = (TIMEOUT > 255) ? $clog2(TIMEOUT+1) : 8;
  logic [AGE_W-1:0] age_q [NS];
`endif

  // up at the top floor and down at the ground floor have no button
  for (genvar f = 0; f < N_FLOORS; f++) begin : g_floor
    assign press[2*f]     = dn_rqst[f];
    assign press[2*f+1]   = up_rqst[f];
    assign slot_ok[2*f]   = (f != 0);
    assign slot_ok[2*f+1] = (f != N_FLOORS-1);
  end

  always_comb begin
    serve_hit = '0;
    for (int s = 0; s < NS; s++)
      serve_hit[s] = serve_valid && (int'(serve_floor) < N_FLOORS) &&
                     (slot_index(32'(serve_floor), serve_up) == s);
  end

  lift_selector #(.N_LIFTS(N_LIFTS), .FLOOR_W(FLOOR_W), .LIFT_W(LIFT_W)) u_sel (
    .lift_floor     (lift_floor),
    .lift_idle      (lift_idle),
    .lift_moving_up (lift_moving_up),
    .call_floor     (ptr_q[PTR_W-1:1]),
    .call_up        (ptr_q[0]),
    .found          (sel_found),
    .best_lift      (sel_lift)
  );

  assign ptr_nxt    = (ptr_q == PTR_W'(NS-1)) ? '0 : ptr_q + 1'b1;
  // the offered call vanished under us (served now, or before the offer went out)
  assign offer_gone = serve_hit[ptr_q] || (slot_q[ptr_q] != CALL_PENDING);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      DISP_SCAN:
        if (slot_q[ptr_q] == CALL_PENDING && sel_found) begin
          load    = 1'b1;
          state_d = DISP_OFFER;
        end else begin
          ptr_d = ptr_nxt;
        end
      DISP_OFFER:
        if (offer_gone || asg.assign_ack) begin
          accept  = !offer_gone;
          state_d = DISP_SCAN;
          ptr_d   = ptr_nxt;
        end
      default: state_d = DISP_SCAN;
    endcase
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      slot_d[s] = slot_q[s];
      if (!slot_ok[s] || serve_hit[s])               slot_d[s] = CALL_IDLE;
      else if (accept && ptr_q == PTR_W'(s))         slot_d[s] = CALL_ASSIGNED;
`ifdef HALL_CALL_REASSIGN_EN
      else if (slot_q[s] == CALL_ASSIGNED && age_q[s] == AGE_W'(TIMEOUT-1))
                                                     slot_d[s] = CALL_PENDING;
`endif
      else if (press[s] && slot_q[s] == CALL_IDLE)   slot_d[s] = CALL_PENDING;
    end
  end

  always_comb begin
    pend_n = '0;
    for (int s = 0; s < NS; s++)
      pend_n = pend_n + CNT_W'(slot_q[s] == CALL_PENDING);
  end

  assign asg.assign_valid = (state_q == DISP_OFFER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q               <= DISP_SCAN;
      ptr_q                 <= '0;
      asg.assign_lift       <= '0;
      asg.assign_floor      <= '0;
      asg.assign_up         <= 1'b0;
      global_up_rqst_status <= '0;
      global_dn_rqst_status <= '0;
      pending_count         <= '0;
      for (int s = 0; s < NS; s++) slot_q[s] <= CALL_IDLE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      slot_q  <= slot_d;
      if (load) begin
        asg.assign_lift  <= sel_lift;
        asg.assign_floor <= ptr_q[PTR_W-1:1];
        asg.assign_up    <= ptr_q[0];
      end
      for (int f = 0; f < N_FLOORS; f++) begin
        global_up_rqst_status[f] <= (slot_q[2*f+1] != CALL_IDLE);
        global_dn_rqst_status[f] <= (slot_q[2*f]   != CALL_IDLE);
      end
      pending_count <= pend_n;
    end
  end

`ifdef HALL_CALL_REASSIGN_EN
  always_ff @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (reset || (slot_d[s] == CALL_ASSIGNED && slot_q[s] != CALL_ASSIGNED)) age_q[s] <= '0;
      else if (slot_q[s] == CALL_ASSIGNED)                                     age_q[s] <= age_q[s] + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_multi_lift_hall_dispatcher.sv
// Bench for multi_lift_hall_dispatcher: selector vector table, directed corner
// sequences, then random traffic against a slot-level behavioural model.
module tb_multi_lift_hall_dispatcher;
  localparam int NF = 12, NL = 10;
  localparam int FW = $clog2(NF), LW = $clog2(NL), NS = 2*NF, CW = $clog2(2*NF+1);

  logic              clk = 1'b0;
  logic              reset;
  logic [NF-1:0]     up_rqst, dn_rqst, lamp_up, lamp_dn;
  logic [NL*FW-1:0]  lift_floor;
  logic [NL-1:0]     lift_idle, lift_moving_up;
  logic              serve_valid, serve_up;
  logic [FW-1:0]     serve_floor;
  logic [CW-1:0]     pending_count;
  int tests = 0, fails = 0;

  multi_lift_hall_dispatcher_if #(.N_FLOORS(NF), .N_LIFTS(NL)) asg ();

  multi_lift_hall_dispatcher #(.N_FLOORS(NF), .N_LIFTS(NL)) dut (
    .clk(clk), .reset(reset), .up_rqst(up_rqst), .dn_rqst(dn_rqst),
    .lift_floor(lift_floor), .lift_idle(lift_idle), .lift_moving_up(lift_moving_up),
    .serve_valid(serve_valid), .serve_floor(serve_floor), .serve_up(serve_up),
    .asg(asg), .global_up_rqst_status(lamp_up), .global_dn_rqst_status(lamp_dn),
    .pending_count(pending_count));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_lift(input int i, input int f, input bit idle, input bit up);
    lift_floor[i*FW +: FW] = FW'(f);
    lift_idle[i]           = idle;
    lift_moving_up[i]      = up;
  endtask

  // busy at the top floor heading up: never eligible for any call
  task automatic busy_all();
    for (int i = 0; i < NL; i++) set_lift(i, NF-1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    up_rqst = '0; dn_rqst = '0; serve_valid = 0; serve_floor = '0; serve_up = 0;
    asg.assign_ack = 0; busy_all();
    reset = 1; tick(); tick(); reset = 0;
  endtask

  task automatic press(input bit up, input int f);
    if (up) up_rqst[f] = 1'b1; else dn_rqst[f] = 1'b1;
    tick();
    up_rqst = '0; dn_rqst = '0;
  endtask

  task automatic serve_call(input int f, input bit up);
    serve_valid = 1; serve_floor = FW'(f); serve_up = up;
    tick();
    serve_valid = 0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 0;
    for (int k = 0; k < max; k++) begin
      if (asg.assign_valid) begin ok = 1; break; end
      tick();
    end
  endtask

  // ---------------- behavioural reference model (0 idle, 1 pending, 2 assigned)
  int m_slot [NS];
  int m_ptr, m_lift, m_floor, m_pc;
  bit m_offer, m_up;
  bit [NF-1:0] m_lamp_up, m_lamp_dn;

  function automatic int pick_lift(input int f, input bit up);
    int best, bc, fl, c;
    bit ok;
    best = -1; bc = 1000;
    for (int i = 0; i < NL; i++) begin
      fl = int'(lift_floor[i*FW +: FW]);
      ok = lift_idle[i] || (lift_moving_up[i] && up && fl < f) || (!lift_moving_up[i] && !up && fl > f);
      c  = (fl > f) ? fl - f : f - fl;
      if (ok && c < bc) begin bc = c; best = i; end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) m_slot[s] = 0;
    m_ptr = 0; m_offer = 0; m_lift = 0; m_floor = 0; m_up = 0; m_pc = 0;
    m_lamp_up = '0; m_lamp_dn = '0;
  endtask

  task automatic model_step();
    int old [NS];
    int sv, p;
    bit pr;
    old = m_slot;
    sv  = (serve_valid && serve_floor < NF) ? 2*int'(serve_floor) + int'(serve_up) : -1;
    m_pc = 0;
    for (int s = 0; s < NS; s++) if (old[s] == 1) m_pc++;
    for (int f = 0; f < NF; f++) begin
      m_lamp_up[f] = old[2*f+1] != 0;
      m_lamp_dn[f] = old[2*f]   != 0;
    end
    for (int s = 0; s < NS; s++) begin
      pr = (s % 2) ? up_rqst[s/2] : dn_rqst[s/2];
      if (s == 0 || s == NS-1 || s == sv) m_slot[s] = 0;
      else if (m_offer && s == m_ptr && asg.assign_ack && old[s] == 1) m_slot[s] = 2;
      else if (pr && old[s] == 0) m_slot[s] = 1;
    end
    if (!m_offer) begin
      p = (old[m_ptr] == 1) ? pick_lift(m_ptr / 2, m_ptr[0]) : -1;
      if (p >= 0) begin m_offer = 1; m_lift = p; m_floor = m_ptr / 2; m_up = m_ptr[0]; end
      else m_ptr = (m_ptr + 1) % NS;
    end else if (sv == m_ptr || old[m_ptr] != 1 || asg.assign_ack) begin
      m_offer = 0; m_ptr = (m_ptr + 1) % NS;
    end
  endtask

  typedef struct {
    int la; int fa; bit ia; bit ua;
    int lb; int fb; bit ib; bit ub;
    int fl; bit up; int exp;
  } vec_t;
  vec_t vt [8];

  initial begin
    bit ok, bad;
    int rl, rf, ru, asc, f;
    int o [3];

    vt[0] = '{0, 0, 1, 0,  1, 11, 0, 1,  3, 1, 0};
    vt[1] = '{2, 7, 1, 0,  5,  5, 1, 0,  6, 0, 2};
    vt[2] = '{2, 7, 1, 0,  5,  6, 1, 0,  6, 0, 5};
    vt[3] = '{1, 2, 0, 1,  3,  9, 1, 0,  5, 1, 1};
    vt[4] = '{4, 10, 0, 0, 6,  3, 1, 0,  8, 0, 4};
    vt[5] = '{7, 6, 0, 1,  8,  0, 1, 0,  5, 1, 8};
    vt[6] = '{9, 2, 0, 0,  0, 11, 1, 0,  3, 0, 0};
    vt[7] = '{3, 4, 1, 0,  9,  4, 1, 0,  4, 1, 3};

    // reset state
    do_reset();
    check("rst_valid", asg.assign_valid, 0);
    check("rst_lift",  asg.assign_lift, 0);
    check("rst_floor", asg.assign_floor, 0);
    check("rst_up",    asg.assign_up, 0);
    check("rst_lamp_up", lamp_up, 0);
    check("rst_lamp_dn", lamp_dn, 0);
    check("rst_pending", pending_count, 0);

    // selector vectors
    for (int v = 0; v < 8; v++) begin
      do_reset();
      set_lift(vt[v].la, vt[v].fa, vt[v].ia, vt[v].ua);
      set_lift(vt[v].lb, vt[v].fb, vt[v].ib, vt[v].ub);
      press(vt[v].up, vt[v].fl);
      wait_valid(2*NF+4, ok);
      check($sformatf("V%0d_offer", v), ok, 1);
      check($sformatf("V%0d_lift", v),  asg.assign_lift, vt[v].exp);
      check($sformatf("V%0d_floor", v), asg.assign_floor, vt[v].fl);
      check($sformatf("V%0d_up", v),    asg.assign_up, vt[v].up);
    end

    // A: press, lamp, offer, ack, sticky assignment, serve
    do_reset();
    set_lift(0, 0, 1, 0);
    press(1, 3);
    tick();
    check("A_lamp_on", lamp_up[3], 1);
    check("A_pending", pending_count, 1);
    wait_valid(2*NF+2, ok);
    check("A_offer", ok, 1);
    check("A_lift", asg.assign_lift, 0);
    check("A_floor", asg.assign_floor, 3);
    check("A_up", asg.assign_up, 1);
    asg.assign_ack = 1; tick(); asg.assign_ack = 0;
    check("A_valid_drop", asg.assign_valid, 0);
    bad = 0;
    for (int k = 0; k < 3*NF; k++) begin tick(); bad |= asg.assign_valid; end
    check("A_sticky", bad, 0);
    check("A_lamp_assigned", lamp_up[3], 1);
    check("A_pending_assigned", pending_count, 0);
    serve_call(3, 1); tick();
    check("A_lamp_off", lamp_up[3], 0);

    // B: offer held stable without ack, then serve (with a simultaneous ack)
    do_reset();
    set_lift(0, 0, 1, 0);
    press(0, 5);
    wait_valid(2*NF+4, ok);
    check("B_offer", ok, 1);
    rl = asg.assign_lift; rf = asg.assign_floor; ru = asg.assign_up;
    for (int k = 0; k < 10; k++) begin
      check("B_hold", {asg.assign_valid, asg.assign_lift, asg.assign_floor, asg.assign_up},
            {1'b1, LW'(rl), FW'(rf), ru[0]});
      tick();
    end
    asg.assign_ack = 1; serve_call(5, 0); asg.assign_ack = 0;
    check("B_serve_drop", asg.assign_valid, 0);
    tick();
    check("B_not_assigned", lamp_dn[5], 0);
    check("B_pending", pending_count, 0);
    press(0, 5);
    wait_valid(2*NF+4, ok);
    check("B_reoffer", ok, 1);
    reset = 1; tick(); reset = 0;
    check("B_rst_valid", asg.assign_valid, 0);
    tick();
    check("B_rst_lamp", lamp_dn[5], 0);

    // C: press+serve same cycle, and the two buttonless slots
    do_reset();
    set_lift(0, 0, 1, 0);
    up_rqst[4] = 1; serve_call(4, 1); up_rqst = '0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin bad |= lamp_up[4] | asg.assign_valid; tick(); end
    check("C_serve_wins", bad, 0);
    dn_rqst[0] = 1; up_rqst[NF-1] = 1;
    tick(); tick(); tick();
    dn_rqst = '0; up_rqst = '0;
    check("C_edge_pending", pending_count, 0);
    check("C_edge_lamps", {lamp_up, lamp_dn}, 0);
    check("C_edge_valid", asg.assign_valid, 0);

    // D: no eligible lift, three calls wait, then offered in pointer order
    do_reset();
    press(1, 2); press(0, 7); press(1, 9);
    tick(); tick();
    check("D_pending3", pending_count, 3);
    bad = 0;
    for (int k = 0; k < 3*NF; k++) begin bad |= asg.assign_valid; tick(); end
    check("D_no_offer", bad, 0);
    set_lift(1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      wait_valid(2*NF+4, ok);
      check("D_offer", ok, 1);
      check("D_lift", asg.assign_lift, 1);
      o[k] = 2*int'(asg.assign_floor) + int'(asg.assign_up);
      asg.assign_ack = 1; tick(); asg.assign_ack = 0;
    end
    check("D_set", ((o[0]==5)||(o[1]==5)||(o[2]==5)) && ((o[0]==14)||(o[1]==14)||(o[2]==14))
                   && ((o[0]==19)||(o[1]==19)||(o[2]==19)), 1);
    asc = int'(o[0] < o[1]) + int'(o[1] < o[2]) + int'(o[2] < o[0]);
    check("D_order", asc, 2);
    tick(); tick();
    check("D_pending0", pending_count, 0);

`ifndef HALL_CALL_REASSIGN_EN
    // E: an assigned call persists with no timeout logic
    do_reset();
    set_lift(0, 0, 1, 0);
    press(1, 1);
    wait_valid(2*NF+4, ok);
    check("E_offer", ok, 1);
    asg.assign_ack = 1; tick(); asg.assign_ack = 0;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin tick(); bad |= asg.assign_valid; end
    check("E_no_reoffer", bad, 0);
    check("E_lamp", lamp_up[1], 1);
`endif

    // random traffic against the model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500 && fails < 20; cyc++) begin
      up_rqst = '0; dn_rqst = '0;
      if ($urandom_range(0, 2) == 0) begin
        f = $urandom_range(0, NF-1);
        if ($urandom_range(0, 1) == 1) up_rqst[f] = 1'b1; else dn_rqst[f] = 1'b1;
      end
      for (int i = 0; i < NL; i++)
        if ($urandom_range(0, 7) == 0)
          set_lift(i, $urandom_range(0, NF-1), $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
      serve_valid = ($urandom_range(0, 4) == 0);
      if (m_offer && $urandom_range(0, 1) == 1) begin
        serve_floor = FW'(m_floor); serve_up = m_up;
      end else begin
        serve_floor = FW'($urandom_range(0, NF+1)); serve_up = $urandom_range(0, 1) == 1;
      end
      asg.assign_ack = ($urandom_range(0, 2) == 0);
      tick();
      model_step();
      check("R_valid", asg.assign_valid, m_offer);
      check("R_payload", {asg.assign_lift, asg.assign_floor, asg.assign_up},
            {LW'(m_lift), FW'(m_floor), m_up});
      check("R_lamps", {lamp_up, lamp_dn}, {m_lamp_up, m_lamp_dn});
      check("R_pending", pending_count, m_pc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_lift_hall_dispatcher.md
Name: multi_lift_hall_dispatcher

Overview:
Next-generation hall-call block for the multi-lift controller. It latches floor up/down button presses into per-call state, selects a lift for each pending call (nearest eligible lift), offers the assignment over a valid/ack handshake, and clears the call when a lift reports service. It drives the global up/down status lamps and sits between the floor button panel and the per-lift controllers.

Parameters:
N_FLOORS, 12, number of floors (>=2)
N_LIFTS, 10, number of lift cars (>=1)
FLOOR_W, $clog2(N_FLOORS), floor index width (derived; not overridden)
TIMEOUT, 255, cycles an ASSIGNED call may remain unserved (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
up_rqst  in  N_FLOORS  up-button pulses/levels, bit f = floor f
dn_rqst  in  N_FLOORS  down-button pulses/levels
lift_floor  in  N_LIFTS*FLOOR_W  current floor per lift, lift i at [i*FLOOR_W +: FLOOR_W]
lift_idle  in  N_LIFTS  lift i parked with no work
lift_moving_up  in  N_LIFTS  lift i travelling up (meaningful when not idle)
serve_valid  in  1  a lift has opened its doors at a hall call
serve_floor  in  FLOOR_W  floor served
serve_up  in  1  1 = up call served, 0 = down call served
assign_valid  out  1  assignment offer valid
assign_lift  out  $clog2(N_LIFTS) (min 1)  selected lift
assign_floor  out  FLOOR_W  call floor
assign_up  out  1  call direction
assign_ack  in  1  lift controller accepts offer
global_up_rqst_status  out  N_FLOORS  up lamp: call PENDING or ASSIGNED
global_dn_rqst_status  out  N_FLOORS  down lamp
pending_count  out  $clog2(2*N_FLOORS+1)  number of calls in PENDING state

Behaviour:
- Call slots: index s = 2*f + dir (dir 1 = up); each slot is IDLE, PENDING or ASSIGNED. Up at floor N_FLOORS-1 and down at floor 0 are ignored (those slots stay IDLE).
- Press: IDLE -> PENDING at the next edge. A press on a PENDING/ASSIGNED slot has no effect. Held buttons are equivalent to one press.
- Serve (serve_valid): the matching slot goes to IDLE from any state. Serve and press to the same slot in the same cycle: serve wins, slot IDLE. A serve with out-of-range serve_floor is ignored.
- Lamps are registered and reflect slot state (not IDLE) one cycle after the slot changes.
- Eligibility for call (f, up): lift idle; or lift moving up with lift_floor < f and call up; or lift moving down with lift_floor > f and call down. Cost = |lift_floor - f|. Minimum cost wins; ties go to the lowest lift index.
- FSM SCAN: pointer ptr over 0..2*N_FLOORS-1. Each cycle, if slot ptr is PENDING and an eligible lift exists, latch the payload, assert assign_valid next cycle and go to OFFER. Otherwise ptr++ (wraps to 0).
- FSM OFFER: assign_* held stable while valid and ack low. On assign_ack: slot -> ASSIGNED, drop valid, ptr++, return to SCAN. If the offered slot is served while in OFFER, drop valid next cycle without ack, ptr++, return to SCAN. An ack in the same cycle as that serve is ignored; serve wins.
- Assignment is sticky: an ASSIGNED slot never re-offers. Only serve (or the optional timeout) releases it.
- Reset: all slots IDLE, ptr 0, FSM SCAN, assign_valid 0, assign_lift/floor/up 0, lamps 0, pending_count 0. Reset mid-OFFER abandons the offer.
- pending_count is registered and updated every cycle from slot state.

Optional Feature:
HALL_CALL_REASSIGN_EN: when defined, each slot carries an 8-bit-or-wider age counter. The counter clears on entry to ASSIGNED and increments every cycle while ASSIGNED. When it reaches TIMEOUT, the slot returns to PENDING and becomes eligible for re-offer. When the macro is undefined, there are no counters, and ASSIGNED persists until served.

Decomposition:
- Package lift_ctrl_pkg holds:
  - call_state_e {CALL_IDLE, CALL_PENDING, CALL_ASSIGNED}
  - disp_state_e {DISP_SCAN, DISP_OFFER}
  - helper function slot_index(floor, dir)
- Sub-module lift_selector: purely combinational. Inputs are lift vectors plus call floor/direction. Outputs are found flag and best lift index. It is instantiated once inside the dispatcher.

Test Plan:
- Reset, then up_rqst[3]=1 for 1 cycle, lift 0 idle at floor 0, others busy -> global_up_rqst_status[3]=1 next cycle; assign_valid asserted with lift=0, floor=3, up=1 within 2*N_FLOORS+2 cycles; ack -> slot ASSIGNED, lamp stays 1; serve(3, up) -> lamp 0.
- Lifts 2 and 5 idle at floors 7 and 5, dn_rqst[6] -> assign_lift=2? No: cost 1 vs 1, tie -> lift 2; with lift 5 at floor 6 instead -> assign_lift=5.
- Hold assign_ack low for 10 cycles -> assign_lift/floor/up stable, valid high throughout; then serve the offered call -> valid drops next cycle, no ASSIGNED state recorded.
- Same-cycle up_rqst[4] and serve(4, up) on an IDLE slot -> lamp never rises; dn_rqst[0] and up_rqst[N_FLOORS-1] -> ignored, pending_count stays 0.
- No eligible lift (all moving away) with 3 calls pending -> pending_count=3, assign_valid stays 0; make lift 1 idle -> all three offered in ptr order.
- With HALL_CALL_REASSIGN_EN, TIMEOUT=20: ack a call, never serve -> slot back to PENDING at cycle 20 and re-offered; without the macro -> remains ASSIGNED after 1000 cycles.
